// File: rtl/clean_session_controller_pkg.sv
// Shared types and helpers for the hood self-clean session controller.
// Mode width and standby code defaults; integrators override them through
// the MODE_WIDTH and STAND_MODE_CODE parameters of the top module.
package clean_session_controller_pkg;

   localparam int DEF_MODE_WIDTH = 3;
   localparam int DEF_STAND_MODE = 0;

   // Session state encodings
   localparam logic [1:0] ST_IDLE_C     = 2'd0;
   localparam logic [1:0] ST_CLEANING_C = 2'd1;
   localparam logic [1:0] ST_DONE_C     = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE     = ST_IDLE_C,
      ST_CLEANING = ST_CLEANING_C,
      ST_DONE     = ST_DONE_C
   } clean_state_e;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/clean_chord_detector.sv
// Menu+normal chord detector: issues exactly one req per press once the
// chord has been held HOLD_CYCLES consecutive cycles.
module clean_chord_detector
   import clean_session_controller_pkg::*;
#(
   parameter int HOLD_CYCLES = 2000000
) (
   input  logic clk,
   input  logic rstn,
   input  logic menu_signal,
   input  logic normal_signal,
   output logic req
);

   localparam int                HOLD_W   = cnt_width(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(HOLD_CYCLES - 1);

   logic              chord;
   logic [HOLD_W-1:0] hold_cnt_q;

   assign chord = menu_signal & normal_signal;

   // Count consecutive chord cycles, saturating so a long hold fires only once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_cnt_q <= '0;
      end else if (!chord) begin
         hold_cnt_q <= '0;
      end else if (hold_cnt_q != HOLD_MAX) begin
         hold_cnt_q <= hold_cnt_q + 1'b1;
      end
   end

   assign req = chord & (hold_cnt_q == HOLD_ARM);

endmodule

// File: rtl/clean_session_controller.sv
// Exhaust-hood self-clean session controller: starts a timed session on a
// held menu+normal chord in standby, counts seconds down, and aborts on a
// second chord or when the mode leaves standby.
// Optional build macro CLEAN_REMINDER_EN adds the usage-based clean reminder.
module clean_session_controller
   import clean_session_controller_pkg::*;
#(
   parameter int                    MODE_WIDTH      = DEF_MODE_WIDTH,
   parameter logic [MODE_WIDTH-1:0] STAND_MODE_CODE = MODE_WIDTH'(DEF_STAND_MODE),
   parameter int                    TICK_DIV        = 100000000,
   parameter int                    CLEAN_SECONDS   = 180,
   parameter int                    HOLD_CYCLES     = 2000000,
   parameter int                    SEC_W           = $clog2(CLEAN_SECONDS + 1),
   parameter int                    REMIND_SECONDS  = 36000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [MODE_WIDTH-1:0] current_mode,
   input  logic                  menu_signal,
   input  logic                  normal_signal,
   output logic                  clean_active,
   output logic [SEC_W-1:0]      remaining_sec,
   output logic                  clean_done,
   output logic                  clean_aborted,
   output logic                  clean_reminder
);

   localparam int                 PRESC_W    = cnt_width(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [SEC_W-1:0]   SEC_START  = SEC_W'(CLEAN_SECONDS);
   localparam logic [SEC_W-1:0]   SEC_ONE    = SEC_W'(1);

   logic               req;
   logic               in_standby;
   clean_state_e       state_q;
   logic [PRESC_W-1:0] presc_q;
   logic [SEC_W-1:0]   remaining_q;
   logic               active_q;
   logic               done_q;
   logic               aborted_q;

   assign in_standby = (current_mode == STAND_MODE_CODE);

   clean_chord_detector #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_chord (
      .clk           (clk),
      .rstn          (rstn),
      .menu_signal   (menu_signal),
      .normal_signal (normal_signal),
      .req           (req)
   );

   // Session FSM with registered outputs; abort takes priority over the final tick.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         remaining_q <= '0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults followed by later assignments in the
         // case below are safe: the last scheduled assignment wins, so the
         // pulses are single-cycle unless a branch re-asserts them.
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req && in_standby) begin
                  state_q     <= ST_CLEANING;
                  active_q    <= 1'b1;
                  remaining_q <= SEC_START;
                  presc_q     <= '0;
               end
            end
            ST_CLEANING: begin
               if (!in_standby || req) begin
                  state_q     <= ST_IDLE;
                  active_q    <= 1'b0;
                  remaining_q <= '0;
                  aborted_q   <= 1'b1;
               end else if (presc_q == PRESC_LAST) begin
                  presc_q <= '0;
                  if (remaining_q == SEC_ONE) begin
                     state_q     <= ST_DONE;
                     active_q    <= 1'b0;
                     remaining_q <= '0;
                     done_q      <= 1'b1;
                  end else begin
                     remaining_q <= remaining_q - 1'b1;
                  end
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q  <= ST_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign clean_active  = active_q;
   assign remaining_sec = remaining_q;
   assign clean_done    = done_q;
   assign clean_aborted = aborted_q;

`ifdef CLEAN_REMINDER_EN
   localparam int               USE_W     = cnt_width(REMIND_SECONDS);
   localparam logic [USE_W-1:0] USE_LIMIT = USE_W'(REMIND_SECONDS);

   logic [PRESC_W-1:0] rem_presc_q;
   logic [USE_W-1:0]   usage_q;
   logic               reminder_q;

   // Accumulate operating seconds outside standby; a completed clean resets usage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rem_presc_q <= '0;
         usage_q     <= '0;
         reminder_q  <= 1'b0;
      end else begin
         if (rem_presc_q == PRESC_LAST) begin
            rem_presc_q <= '0;
         end else begin
            rem_presc_q <= rem_presc_q + 1'b1;
         end
         if (done_q) begin
            usage_q <= '0;
         end else if ((rem_presc_q == PRESC_LAST) && !in_standby && (usage_q != USE_LIMIT)) begin
            usage_q <= usage_q + 1'b1;
         end
         reminder_q <= (usage_q >= USE_LIMIT);
      end
   end

   assign clean_reminder = reminder_q;
`else
   assign clean_reminder = 1'b0;
`endif

endmodule

// File: tb/tb_clean_session_controller.sv
// Directed self-checking bench for clean_session_controller.
// Small parameters: 4 cycles per second, 3 s session, 2-cycle chord hold.
module tb_clean_session_controller;

   localparam int             MODE_WIDTH = 3;
   localparam logic [2:0]     STAND      = 3'd2;
   localparam logic [2:0]     OTHER      = 3'd1;
   localparam int             TICK_DIV   = 4;
   localparam int             CLEAN_SEC  = 3;
   localparam int             HOLD       = 2;
   localparam int             REMIND     = 5;
   localparam int             SEC_W      = $clog2(CLEAN_SEC + 1);

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic [MODE_WIDTH-1:0] current_mode = STAND;
   logic                  menu_signal = 1'b0;
   logic                  normal_signal = 1'b0;
   logic                  clean_active;
   logic [SEC_W-1:0]      remaining_sec;
   logic                  clean_done;
   logic                  clean_aborted;
   logic                  clean_reminder;

   int pass_cnt  = 0;
   int check_cnt = 0;

   clean_session_controller #(
      .MODE_WIDTH      (MODE_WIDTH),
      .STAND_MODE_CODE (STAND),
      .TICK_DIV        (TICK_DIV),
      .CLEAN_SECONDS   (CLEAN_SEC),
      .HOLD_CYCLES     (HOLD),
      .SEC_W           (SEC_W),
      .REMIND_SECONDS  (REMIND)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .current_mode   (current_mode),
      .menu_signal    (menu_signal),
      .normal_signal  (normal_signal),
      .clean_active   (clean_active),
      .remaining_sec  (remaining_sec),
      .clean_done     (clean_done),
      .clean_aborted  (clean_aborted),
      .clean_reminder (clean_reminder)
   );

   always #5 clk = ~clk;

   // Observed outputs packed as {active, done, aborted, remaining_sec}
   function automatic logic [SEC_W+2:0] obs();
      return {clean_active, clean_done, clean_aborted, remaining_sec};
   endfunction

   function automatic logic [SEC_W+2:0] expv(input bit a, input bit d, input bit ab, input int r);
      logic [SEC_W-1:0] rs;
      rs = SEC_W'(r);
      return {a, d, ab, rs};
   endfunction

   // Advance one clock edge and settle 1 ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold the chord for n edges, then release it
   task automatic press(input int n);
      menu_signal   = 1'b1;
      normal_signal = 1'b1;
      repeat (n) tick();
      menu_signal   = 1'b0;
      normal_signal = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      check_cnt++;
      if (obs() !== expv(0, 0, 0, 0)) $display("FAIL reset_outs: got %b expected %b", obs(), expv(0, 0, 0, 0));
      else pass_cnt++;
      check_cnt++;
      if (clean_reminder !== 1'b0) $display("FAIL reset_reminder: got %b expected 0", clean_reminder);
      else pass_cnt++;
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_session();
      current_mode = STAND;
      press(HOLD);
      for (int k = 0; k < CLEAN_SEC * TICK_DIV; k++) begin
         if (k > 0) tick();
         check_cnt++;
         if (obs() !== expv(1, 0, 0, CLEAN_SEC - k / TICK_DIV))
            $display("FAIL session_cycle%0d: got %b expected %b", k, obs(), expv(1, 0, 0, CLEAN_SEC - k / TICK_DIV));
         else pass_cnt++;
      end
      tick();
      check_cnt++;
      if (obs() !== expv(0, 1, 0, 0)) $display("FAIL session_done: got %b expected %b", obs(), expv(0, 1, 0, 0));
      else pass_cnt++;
      tick();
      check_cnt++;
      if (obs() !== expv(0, 0, 0, 0)) $display("FAIL session_after_done: got %b expected %b", obs(), expv(0, 0, 0, 0));
      else pass_cnt++;
   endtask

   task automatic test_no_start();
      current_mode = STAND;
      press(1);
      for (int k = 0; k < 6; k++) begin
         check_cnt++;
         if (obs() !== expv(0, 0, 0, 0)) $display("FAIL short_press%0d: got %b expected %b", k, obs(), expv(0, 0, 0, 0));
         else pass_cnt++;
         tick();
      end
      current_mode = OTHER;
      press(HOLD);
      for (int k = 0; k < 6; k++) begin
         check_cnt++;
         if (obs() !== expv(0, 0, 0, 0)) $display("FAIL non_standby%0d: got %b expected %b", k, obs(), expv(0, 0, 0, 0));
         else pass_cnt++;
         tick();
      end
      current_mode = STAND;
      tick();
   endtask

   task automatic test_mode_abort();
      current_mode = STAND;
      press(HOLD);
      repeat (TICK_DIV) tick();
      check_cnt++;
      if (obs() !== expv(1, 0, 0, 2)) $display("FAIL abort_pre: got %b expected %b", obs(), expv(1, 0, 0, 2));
      else pass_cnt++;
      current_mode = OTHER;
      tick();
      check_cnt++;
      if (obs() !== expv(0, 0, 1, 0)) $display("FAIL mode_abort: got %b expected %b", obs(), expv(0, 0, 1, 0));
      else pass_cnt++;
      for (int k = 0; k < 14; k++) begin
         tick();
         check_cnt++;
         if (obs() !== expv(0, 0, 0, 0)) $display("FAIL mode_abort_after%0d: got %b expected %b", k, obs(), expv(0, 0, 0, 0));
         else pass_cnt++;
      end
      current_mode = STAND;
      tick();
   endtask

   task automatic test_chord_abort();
      current_mode = STAND;
      press(HOLD);
      tick();
      menu_signal   = 1'b1;
      normal_signal = 1'b1;
      tick();
      tick();
      check_cnt++;
      if (obs() !== expv(0, 0, 1, 0)) $display("FAIL chord_abort: got %b expected %b", obs(), expv(0, 0, 1, 0));
      else pass_cnt++;
      for (int k = 0; k < 20; k++) begin
         tick();
         check_cnt++;
         if (obs() !== expv(0, 0, 0, 0)) $display("FAIL held_no_restart%0d: got %b expected %b", k, obs(), expv(0, 0, 0, 0));
         else pass_cnt++;
      end
      menu_signal   = 1'b0;
      normal_signal = 1'b0;
      tick();
      press(HOLD);
      check_cnt++;
      if (obs() !== expv(1, 0, 0, 3)) $display("FAIL restart: got %b expected %b", obs(), expv(1, 0, 0, 3));
      else pass_cnt++;
      repeat (CLEAN_SEC * TICK_DIV) tick();
      check_cnt++;
      if (obs() !== expv(0, 1, 0, 0)) $display("FAIL restart_done: got %b expected %b", obs(), expv(0, 1, 0, 0));
      else pass_cnt++;
      tick();
   endtask

   task automatic test_abort_at_wrap();
      current_mode = STAND;
      press(HOLD);
      repeat (CLEAN_SEC * TICK_DIV - 1) tick();
      check_cnt++;
      if (obs() !== expv(1, 0, 0, 1)) $display("FAIL wrap_pre: got %b expected %b", obs(), expv(1, 0, 0, 1));
      else pass_cnt++;
      current_mode = OTHER;
      tick();
      check_cnt++;
      if (obs() !== expv(0, 0, 1, 0)) $display("FAIL wrap_abort: got %b expected %b", obs(), expv(0, 0, 1, 0));
      else pass_cnt++;
      tick();
      check_cnt++;
      if (obs() !== expv(0, 0, 0, 0)) $display("FAIL wrap_after: got %b expected %b", obs(), expv(0, 0, 0, 0));
      else pass_cnt++;
      current_mode = STAND;
      tick();
   endtask

   task automatic test_reset_mid_session();
      current_mode = STAND;
      press(HOLD);
      repeat (5) tick();
      check_cnt++;
      if (obs() !== expv(1, 0, 0, 2)) $display("FAIL rst_pre: got %b expected %b", obs(), expv(1, 0, 0, 2));
      else pass_cnt++;
      rstn = 1'b0;
      #1;
      check_cnt++;
      if (obs() !== expv(0, 0, 0, 0)) $display("FAIL rst_async: got %b expected %b", obs(), expv(0, 0, 0, 0));
      else pass_cnt++;
      repeat (2) tick();
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 14; k++) begin
         tick();
         check_cnt++;
         if (obs() !== expv(0, 0, 0, 0)) $display("FAIL rst_after%0d: got %b expected %b", k, obs(), expv(0, 0, 0, 0));
         else pass_cnt++;
      end
   endtask

`ifdef CLEAN_REMINDER_EN
   task automatic test_reminder();
      current_mode = OTHER;
      repeat (24) tick();
      check_cnt++;
      if (clean_reminder !== 1'b1) $display("FAIL reminder_set: got %b expected 1", clean_reminder);
      else pass_cnt++;
      current_mode = STAND;
      press(HOLD);
      repeat (CLEAN_SEC * TICK_DIV) tick();
      check_cnt++;
      if (obs() !== expv(0, 1, 0, 0)) $display("FAIL reminder_done: got %b expected %b", obs(), expv(0, 1, 0, 0));
      else pass_cnt++;
      repeat (2) tick();
      check_cnt++;
      if (clean_reminder !== 1'b0) $display("FAIL reminder_cleared: got %b expected 0", clean_reminder);
      else pass_cnt++;
      current_mode = OTHER;
      repeat (24) tick();
      check_cnt++;
      if (clean_reminder !== 1'b1) $display("FAIL reminder_reset: got %b expected 1", clean_reminder);
      else pass_cnt++;
      current_mode = STAND;
      press(HOLD);
      repeat (2) tick();
      current_mode = OTHER;
      tick();
      check_cnt++;
      if (obs() !== expv(0, 0, 1, 0)) $display("FAIL reminder_abort: got %b expected %b", obs(), expv(0, 0, 1, 0));
      else pass_cnt++;
      repeat (4) tick();
      check_cnt++;
      if (clean_reminder !== 1'b1) $display("FAIL reminder_kept: got %b expected 1", clean_reminder);
      else pass_cnt++;
      current_mode = STAND;
      tick();
   endtask
`else
   task automatic test_reminder();
      current_mode = OTHER;
      for (int k = 0; k < 24; k++) begin
         tick();
         check_cnt++;
         if (clean_reminder !== 1'b0) $display("FAIL reminder_off%0d: got %b expected 0", k, clean_reminder);
         else pass_cnt++;
      end
      current_mode = STAND;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_session();
      test_no_start();
      test_mode_abort();
      test_chord_abort();
      test_abort_at_wrap();
      test_reset_mid_session();
      test_reminder();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
